// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry skid buffer between ALU and register file, owning the status flags
module alu_result_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_f,
  input  logic          in_z,
  input  logic          in_v,
  input  logic          in_n,
  input  logic          in_c,
  input  logic [AW-1:0] in_da,
  input  logic          in_rw,
  input  logic          in_ls,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_f,
  output logic [AW-1:0] out_da,
  output logic          out_rw,
  output logic          st_z,
  output logic          st_v,
  output logic          st_n,
  output logic          st_c
);
  // entry layout: {f, z, v, n, c, da, rw, ls}
  localparam int PW = DW + AW + 6;
  logic [PW-1:0] main_q, skid_q, in_p;
  logic main_valid, skid_valid, in_fire, out_fire;
  logic [3:0] st;
  assign in_p = {in_f, in_z, in_v, in_n, in_c, in_da, in_rw, in_ls};
  assign in_ready = ~skid_valid;
  assign out_valid = main_valid;
  assign in_fire = in_valid & ~skid_valid;
  assign out_fire = main_valid & out_ready;
  assign out_f = main_q[PW-1 -: DW];
  assign out_da = main_q[AW+1:2];
  assign out_rw = main_q[1];
  assign {st_z, st_v, st_n, st_c} = st;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      st <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (out_fire && main_q[0]) st <= main_q[AW+5:AW+2];
      if (!main_valid || out_fire) begin
        if (skid_valid) begin
          main_q <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= in_fire;
          if (in_fire) main_q <= in_p;
        end
      end else if (in_fire) begin
        skid_q <= in_p;
        skid_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard plus directed and table-driven checks of the result stage
module tb_alu_result_stage;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_rw, st_z, st_v, st_n, st_c;
  logic in_z = 1'b0, in_v = 1'b0, in_n = 1'b0, in_c = 1'b0, in_rw = 1'b0, in_ls = 1'b0;
  logic [31:0] in_f = '0, out_f;
  logic [4:0] in_da = '0, out_da;

  typedef struct {
    logic [31:0] f;
    logic [3:0]  zvnc;
    logic [4:0]  da;
    logic        rw;
    logic        ls;
  } pay_t;

  typedef struct {
    pay_t       p;
    logic       rdy;
    logic [3:0] exp_st;
  } vec_t;

  pay_t q[$];
  logic [3:0] st_exp = '0;
  int checks = 0, errors = 0;

  alu_result_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_f(in_f), .in_z(in_z), .in_v(in_v), .in_n(in_n), .in_c(in_c),
    .in_da(in_da), .in_rw(in_rw), .in_ls(in_ls),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_da(out_da), .out_rw(out_rw),
    .st_z(st_z), .st_v(st_v), .st_n(st_n), .st_c(st_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic pay_t mk(input logic [31:0] f, input logic [3:0] zvnc,
                              input logic [4:0] da, input logic rw, input logic ls);
    pay_t p;
    p.f = f; p.zvnc = zvnc; p.da = da; p.rw = rw; p.ls = ls;
    return p;
  endfunction

  task automatic drive(input logic v, input pay_t p);
    in_valid = v;
    in_f = p.f;
    {in_z, in_v, in_n, in_c} = p.zvnc;
    in_da = p.da;
    in_rw = p.rw;
    in_ls = p.ls;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input pay_t p);
    logic done;
    done = 1'b0;
    drive(1'b1, p);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        cyc();
        in_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for f=%h", p.f);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries still expected, out_valid=%b", q.size(), out_valid);
    end
    cyc();
  endtask

  // scoreboard: expected entries are queued on in_fire and compared on out_fire
  always @(negedge clk) begin
    if (rst_n) begin
      chk("st", 64'({st_z, st_v, st_n, st_c}), 64'(st_exp));
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dup: unexpected output f=%h da=%0d", out_f, out_da);
          end else begin
            pay_t e;
            e = q.pop_front();
            chk("out", 64'({out_f, out_da, out_rw}), 64'({e.f, e.da, e.rw}));
            if (e.ls) st_exp = e.zvnc;
          end
        end
        if (in_valid && in_ready) q.push_back(mk(in_f, {in_z, in_v, in_n, in_c}, in_da, in_rw, in_ls));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{mk(32'h12345678, 4'b0000, 5'd9,  1'b1, 1'b0), 1'b1, 4'b1000};
    tbl[1] = '{mk(32'h00000000, 4'b1001, 5'd10, 1'b1, 1'b1), 1'b0, 4'b1001};
    tbl[2] = '{mk(32'h7FFFFFFF, 4'b0100, 5'd31, 1'b0, 1'b0), 1'b1, 4'b1001};
    tbl[3] = '{mk(32'h80000001, 4'b0011, 5'd0,  1'b1, 1'b1), 1'b0, 4'b0011};
    tbl[4] = '{mk(32'hA5A5A5A5, 4'b1111, 5'd17, 1'b0, 1'b1), 1'b1, 4'b1111};
    tbl[5] = '{mk(32'h5A5A5A5A, 4'b0000, 5'd30, 1'b1, 1'b1), 1'b0, 4'b0000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_f", 64'(out_f), 64'(0));
    chk("rst_st", 64'({st_z, st_v, st_n, st_c}), 64'(0));
    rst_n = 1'b1;
    cyc();

    // stream of three results with out_ready high
    out_ready = 1'b1;
    drive(1'b1, mk(32'h00000005, 4'b0000, 5'd1, 1'b1, 1'b0));
    cyc();
    drive(1'b1, mk(32'hFFFFFFFF, 4'b0000, 5'd2, 1'b1, 1'b0));
    @(negedge clk);
    chk("stream_valid1", 64'(out_valid), 64'(1));
    chk("stream_f1", 64'(out_f), 64'h5);
    chk("stream_ready", 64'(in_ready), 64'(1));
    cyc();
    drive(1'b1, mk(32'h00000000, 4'b0000, 5'd3, 1'b1, 1'b0));
    @(negedge clk);
    chk("stream_f2", 64'(out_f), 64'hFFFFFFFF);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_da3", 64'(out_da), 64'(3));
    chk("stream_valid3", 64'(out_valid), 64'(1));
    cyc();
    @(negedge clk);
    chk("stream_empty", 64'(out_valid), 64'(0));
    cyc();

    // back-pressure fills main and skid
    out_ready = 1'b0;
    drive(1'b1, mk(32'h0000000A, 4'b0000, 5'd4, 1'b1, 1'b0));
    cyc();
    drive(1'b1, mk(32'h0000000B, 4'b0000, 5'd5, 1'b1, 1'b0));
    @(negedge clk);
    chk("bp_ready_b", 64'(in_ready), 64'(1));
    cyc();
    drive(1'b1, mk(32'h0000000C, 4'b0000, 5'd6, 1'b1, 1'b0));
    @(negedge clk);
    chk("bp_ready_full", 64'(in_ready), 64'(0));
    chk("bp_main_a", 64'(out_f), 64'hA);
    cyc();
    @(negedge clk);
    chk("bp_ready_hold", 64'(in_ready), 64'(0));
    cyc();
    out_ready = 1'b1;
    send(mk(32'h0000000C, 4'b0000, 5'd6, 1'b1, 1'b0));
    drain();
    chk("bp_last_f", 64'(out_f), 64'hC);

    // status commit only for ls entries
    send(mk(32'h80000000, 4'b0110, 5'd5, 1'b1, 1'b1));
    drain();
    chk("sr_vnz", 64'({st_v, st_n, st_z}), 64'(3'b110));
    send(mk(32'h00000000, 4'b1000, 5'd6, 1'b1, 1'b0));
    drain();
    chk("sr_hold", 64'({st_z, st_v, st_n, st_c}), 64'(4'b0110));

    // flush with both entries full, then flush with a same-cycle in_fire
    out_ready = 1'b0;
    send(mk(32'h00000011, 4'b1000, 5'd7, 1'b1, 1'b1));
    send(mk(32'h00000022, 4'b1000, 5'd8, 1'b1, 1'b1));
    flush = 1'b1;
    out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_valid", 64'(out_valid), 64'(0));
    chk("fl_ready", 64'(in_ready), 64'(1));
    chk("fl_st_z", 64'(st_z), 64'(0));
    cyc();
    drive(1'b1, mk(32'h0000DEAD, 4'b1000, 5'd9, 1'b1, 1'b1));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_in_drop", 64'(out_valid), 64'(0));
    chk("fl_payload", 64'(out_f), 64'h11);
    drain();

    // asynchronous reset with both entries full
    send(mk(32'h00000033, 4'b0001, 5'd7, 1'b1, 1'b1));
    drain();
    chk("ar_st_c", 64'(st_c), 64'(1));
    out_ready = 1'b0;
    send(mk(32'h00000044, 4'b0000, 5'd1, 1'b1, 1'b1));
    send(mk(32'h00000055, 4'b0000, 5'd2, 1'b1, 1'b1));
    chk("ar_full", 64'(in_ready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'(0));
    chk("ar_st", 64'({st_z, st_v, st_n, st_c}), 64'(0));
    chk("ar_f", 64'(out_f), 64'(0));
    q.delete();
    st_exp = '0;
    #3;
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    chk("ar_ready", 64'(in_ready), 64'(1));
    chk("ar_empty", 64'(out_valid), 64'(0));
    cyc();

    // compare-only entry updates flags without a register write
    out_ready = 1'b1;
    drive(1'b1, mk(32'h00000000, 4'b1000, 5'd8, 1'b0, 1'b1));
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("cmp_valid", 64'(out_valid), 64'(1));
    chk("cmp_rw", 64'(out_rw), 64'(0));
    chk("cmp_z_before", 64'(st_z), 64'(0));
    cyc();
    @(negedge clk);
    chk("cmp_z_after", 64'(st_z), 64'(1));
    cyc();

    foreach (tbl[i]) begin
      out_ready = tbl[i].rdy;
      send(tbl[i].p);
      drain();
      chk($sformatf("tbl%0d_st", i), 64'({st_z, st_v, st_n, st_c}), 64'(tbl[i].exp_st));
      chk($sformatf("tbl%0d_f", i), 64'(out_f), 64'(tbl[i].p.f));
    end

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the ALU. Captures each ALU result (F, Z, V, N, C) with its destination register address and control bits.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides, and presents them to the register-file write port.
- Owns the architectural status register (Z, V, N, C), which is committed only when a result with load-status set leaves the stage.

Parameters:
- DW, 32, data width of the ALU result.
- AW, 5, destination register address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush; discards all buffered entries.
- in_valid  input  1  upstream has a result this cycle.
- in_ready  output  1  stage can accept a result this cycle.
- in_f  input  DW  ALU result F.
- in_z, in_v, in_n, in_c  input  1 each  ALU flags.
- in_da  input  AW  destination register address.
- in_rw  input  1  result is to be written to the register file.
- in_ls  input  1  result updates the status register.
- out_valid  output  1  stage presents a result.
- out_ready  input  1  downstream accepts the result.
- out_f  output  DW  result to register file.
- out_da  output  AW  destination address.
- out_rw  output  1  register write enable (qualified by out_valid & out_ready downstream).
- st_z, st_v, st_n, st_c  output  1 each  architectural status register.

Behaviour:
- Clocking: single clock domain.
- Reset: rst_n is asynchronous, active-low.
  - Clears main_valid, skid_valid, all payload registers (out_f = 0, out_da = 0, out_rw = 0) and st_z/v/n/c = 0.
  - After reset: out_valid = 0, in_ready = 1.
  - Reset asserted mid-operation drops every buffered entry without committing flags.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A valid source holds its payload stable until it fires.
- in_ready = ~skid_valid. It is a registered value with no combinational path from out_ready.
- out_valid = main_valid. Outputs are driven from the main register only.
- Payload per entry: {f, z, v, n, c, da, rw, ls}.
- Main/skid update each cycle, in priority order:
  1. flush = 1: main_valid = 0, skid_valid = 0. A same-cycle in_fire is dropped. A same-cycle out_fire is not committed (no status update). Payloads are not cleared.
  2. Main empty or out_fire, and skid_valid = 1: skid moves to main, skid_valid = 0. A simultaneous in_fire cannot occur because in_ready = 0.
  3. Main empty or out_fire, and skid empty: main loads the input if in_fire (main_valid = 1), else main_valid = 0.
  4. Main full, no out_fire, and in_fire: the input goes to skid, skid_valid = 1.
- Latency and throughput: 1 cycle from in_fire to out_valid. Sustained throughput is 1 result per cycle with out_ready held high.
- Back-pressure: out_ready low for 2+ cycles fills both entries, and in_ready drops the cycle after skid fills. No entry is ever lost or duplicated, and order is strictly FIFO.
- Status register:
  - On out_fire with ls = 1 (and no flush), st_* takes the entry's z/v/n/c on that clock edge.
  - ls = 0 leaves st_* unchanged.
  - rw and ls are independent. An entry with rw = 0, ls = 1 (compare-style) updates flags only. An entry with rw = 0, ls = 0 passes through as a no-op.
- When out_valid = 0, out_f/out_da/out_rw hold their last value and are never X. Downstream qualifies them with out_valid.
- No arithmetic is performed in this stage. Flags pass through unmodified.

Test Plan:
- Reset then stream: deassert rst_n, then send 3 results (F = 0x00000005 da = 1; F = 0xFFFFFFFF da = 2; F = 0 da = 3, all rw = 1) with out_ready = 1 → out_valid high from cycle 1, the three results appear on consecutive cycles in order, and in_ready stays 1.
- Back-pressure: out_ready = 0 while sending A, B, C → A in main, B in skid, in_ready = 0 after B is accepted, C held upstream. Raise out_ready → A, B, C emerge in order with no loss or duplicate.
- Status commit: send ADD overflow (F = 0x80000000, V = 1, N = 1, ls = 1), then an AND with ls = 0 and Z = 1 → after the first out_fire st_v = 1, st_n = 1, st_z = 0. st_* stays unchanged after the second.
- Flush with full buffer: fill both entries (ls = 1, Z = 1), assert flush for 1 cycle with out_ready = 1 → out_valid = 0 and in_ready = 1 next cycle, st_z stays 0, and an in_fire in the flush cycle never appears at the output.
- Async reset mid-operation: with both entries full and st_c = 1, pulse rst_n low between clock edges → out_valid, st_* and out_f go to 0 immediately. After release, in_ready = 1.
- Compare-only entry: rw = 0, ls = 1, Z = 1, F = 0 → out_rw = 0 on out_fire, and st_z = 1 on the next edge.
